fifo_sync_param: RTL

Parametrised synchronous FIFO with circular read/write pointers. It supports configurable width and depth, occupancy count, almost-full and almost-empty thresholds, and a selectable read mode (registered or first-word-fall-through). It is the general-purpose buffer between producer/consumer blocks on a single clock domain. Rejected operations are flagged per cycle, and the FIFO state is never corrupted by a rejected operation.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_sync_param_mem.sv | 28 ++
 rtl/fifo_sync_param.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width derivation and parameter legality checks.
// Latency: none (elaboration-time constant functions only).
// Backpressure: not applicable; reused by sync, async and multi-channel FIFOs.
package fifo_pkg;

    // Ceiling log2 for positive sizes; 1 maps to 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer width for a FIFO of the given depth; never narrower than 1 bit.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

    // Depth must be a power of two so the pointers wrap for free.
    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_legal(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_legal(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible at the read port after the write edge; read is combinational.
// Backpressure: none; the caller gates we_i with its own accept logic.
module fifo_sync_param_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost thresholds and selectable read mode.
// Latency: 1 cycle read in registered mode; head visible combinationally in FWFT mode.
// Backpressure: writes when full are dropped (unless a read pops the same cycle), reads when empty dropped; both pulse a flag.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   en_write,
    input  logic                   en_read,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 and at least 2");
    end
    if (!af_legal(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH out of range 1..DEPTH");
    end
    if (!ae_legal(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO still takes a write if the same cycle frees a slot.
    assign rd_acc = en_read & ~empty;
    assign wr_acc = en_write & (~full | rd_acc);

    fifo_sync_param_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Pointer, occupancy and reject-flag next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = en_write & ~wr_acc;
        unf_d    = en_read & ~rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head of queue is presented directly; data is meaningless while empty.
        assign data_out  = mem_rdata;
        assign valid_out = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              vld_q, vld_d;

        // Capture the head on an accepted read; otherwise hold data, drop valid.
        always_comb begin
            dout_d = dout_q;
            vld_d  = 1'b0;
            if (rd_acc) begin
                dout_d = mem_rdata;
                vld_d  = 1'b1;
            end
        end

        // Registered read output.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                vld_q  <= vld_d;
            end
        end

        assign data_out  = dout_q;
        assign valid_out = vld_q;
    end

endmodule
